// File: rtl/stopwatch_core.sv
// mm:ss stopwatch core: slow-clock tick counting, run/stop/adjust FSM.
// Optional blinking of the adjusted field: define STOPWATCH_BLINK_EN.
module stopwatch_core #(
  parameter int TICKS_PER_SEC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blink
);

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  localparam logic [3:0] SUB_MAX = 4'(TICKS_PER_SEC - 1);

  state_t     state_q;
  logic       running_q;
  logic       slow_s1_q, slow_s2_q, slow_d_q;
  logic       pause_s1_q, pause_s2_q, pause_d_q;
  logic       clr_s1_q, clr_s2_q;
  logic [3:0] sub_q;
  logic       stick_q;
  logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic [8:0] sec_r, min_r;
  logic       clr, qtick, pedge, mode_chg, pause_go, inc;

  // Two-digit BCD increment 00..59, returns {carry, tens, ones}
  function automatic logic [8:0] inc2(input logic [3:0] t,
                                      input logic [3:0] o);
    logic [8:0] r;
    if (o >= 4'd9) begin
      if (t >= 4'd5) r = {1'b1, 4'd0, 4'd0};
      else           r = {1'b0, t + 4'd1, 4'd0};
    end else begin
      r = {1'b0, t, o + 4'd1};
    end
    return r;
  endfunction

  assign clr      = clr_s2_q;
  assign qtick    = slow_s2_q & ~slow_d_q;
  assign pedge    = pause_s2_q & ~pause_d_q;
  assign mode_chg = adj ? (state_q != ADJUST) : (state_q == ADJUST);
  assign pause_go = pedge & ~adj & (state_q != ADJUST);
  assign inc      = stick_q & ~clr & ~mode_chg & ~pause_go
                  & (state_q != STOP);
  assign sec_r    = inc2(sec_tens_q, sec_ones_q);
  assign min_r    = inc2(min_tens_q, min_ones_q);

  // Synchronizers, edge flops, sub-second counter and stick pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slow_s1_q  <= 1'b0;
      slow_s2_q  <= 1'b0;
      slow_d_q   <= 1'b0;
      pause_s1_q <= 1'b0;
      pause_s2_q <= 1'b0;
      pause_d_q  <= 1'b0;
      clr_s1_q   <= 1'b0;
      clr_s2_q   <= 1'b0;
      sub_q      <= 4'd0;
      stick_q    <= 1'b0;
    end else begin
      slow_s1_q  <= slow_clk;
      slow_s2_q  <= slow_s1_q;
      slow_d_q   <= slow_s2_q;
      pause_s1_q <= btn_pause;
      pause_s2_q <= pause_s1_q;
      pause_d_q  <= pause_s2_q;
      clr_s1_q   <= btn_clear;
      clr_s2_q   <= clr_s1_q;
      stick_q    <= 1'b0;
      if (clr) begin
        sub_q <= 4'd0;
      end else if (qtick) begin
        if (sub_q >= SUB_MAX) begin
          sub_q   <= 4'd0;
          stick_q <= 1'b1;
        end else begin
          sub_q <= sub_q + 4'd1;
        end
      end
    end
  end

  // Next time value: clear, full carry chain in RUN, one field in ADJUST
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    if (clr) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (inc) begin
      unique case (1'b1)
        (state_q == RUN): begin
          {sec_tens_d, sec_ones_d} = sec_r[7:0];
          if (sec_r[8]) {min_tens_d, min_ones_d} = min_r[7:0];
        end
        (state_q == ADJUST && sel):
          {min_tens_d, min_ones_d} = min_r[7:0];
        (state_q == ADJUST && !sel):
          {sec_tens_d, sec_ones_d} = sec_r[7:0];
        default: ;
      endcase
    end
  end

  // Time digit registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

`ifdef STOPWATCH_BLINK_EN
  logic blink_q;
`endif

  // Mode FSM with registered running and blink outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= STOP;
      running_q <= 1'b0;
`ifdef STOPWATCH_BLINK_EN
      blink_q   <= 1'b1;
`endif
    end else begin
      if (!clr) begin
        if (mode_chg) begin
          state_q   <= adj ? ADJUST : STOP;
          running_q <= 1'b0;
        end else if (pause_go) begin
          state_q   <= (state_q == STOP) ? RUN : STOP;
          running_q <= (state_q == STOP);
        end
      end
`ifdef STOPWATCH_BLINK_EN
      if (state_q != ADJUST)
        blink_q <= 1'b1;
      else if (qtick && !sub_q[0])
        blink_q <= ~blink_q;
`endif
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign running  = running_q;
`ifdef STOPWATCH_BLINK_EN
  assign blink    = blink_q;
`else
  assign blink    = 1'b1;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core (TICKS_PER_SEC = 4).
// Time is read as a 16-bit BCD word mm:ss, e.g. 16'h5958.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_clk = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clear = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blink;
  logic [15:0] tv;

  int n_chk = 0;
  int n_fail = 0;

  stopwatch_core #(.TICKS_PER_SEC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .slow_clk  (slow_clk),
    .btn_pause (btn_pause),
    .btn_clear (btn_clear),
    .adj       (adj),
    .sel       (sel),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  assign tv = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic slow_periods(input int n);
    repeat (n) begin
      slow_clk = 1'b1;
      tick(8);
      slow_clk = 1'b0;
      tick(8);
    end
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    tick(4);
    btn_pause = 1'b0;
    tick(4);
  endtask

  // One slow period; counts clocks from slow_clk rise to sec_ones==1
  task automatic slow_latency(input string tag);
    int cnt;
    cnt = 0;
    slow_clk = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
    end while (sec_ones != 4'd1 && cnt < 10);
    check(tag, cnt, 4);
    if (cnt < 8) tick(8 - cnt);
    slow_clk = 1'b0;
    tick(8);
  endtask

  initial begin
    logic b0, b2, b4;
    tick(3);
    check("rst_time", tv, 16'h0000);
    check("rst_run", running, 0);
    check("rst_blink", blink, 1);
    rst_n = 1'b1;
    tick(2);

    press_pause();
    check("run_on", running, 1);
    slow_periods(3);
    check("run_3q", tv, 16'h0000);
    slow_latency("run_lat");
    check("run_4q", tv, 16'h0001);

    press_pause();
    check("stop_run", running, 0);
    slow_periods(4);
    check("stop_hold", tv, 16'h0001);

    adj = 1'b1;
    tick(4);
    check("adj_run", running, 0);
    btn_clear = 1'b1;
    tick(4);
    btn_clear = 1'b0;
    tick(4);
    check("adj_clr", tv, 16'h0000);
    press_pause();
    sel = 1'b0;
    slow_periods(236);
    check("adj_s59", tv, 16'h0059);
    b0 = blink;
    slow_periods(2);
    b2 = blink;
    slow_periods(2);
    b4 = blink;
    check("adj_swrap", tv, 16'h0000);
`ifdef STOPWATCH_BLINK_EN
    check("blink_t2", b2, !b0);
    check("blink_t4", b4, b0);
`else
    check("blink_c2", b2, 1);
    check("blink_c4", b4, 1);
`endif
    sel = 1'b1;
    slow_periods(236);
    check("adj_m59", tv, 16'h5900);
    sel = 1'b0;
    slow_periods(232);
    check("adj_5958", tv, 16'h5958);
    sel = 1'b1;
    slow_periods(4);
    check("adj_mwrap", tv, 16'h0058);
    slow_periods(236);
    check("adj_back", tv, 16'h5958);
    adj = 1'b0;
    tick(4);
    check("adj_exit", running, 0);
    check("exit_blink", blink, 1);

    press_pause();
    check("run2_on", running, 1);
    slow_periods(4);
    check("run_5959", tv, 16'h5959);
    slow_periods(4);
    check("run_wrap", tv, 16'h0000);

    slow_periods(36);
    check("run_0009", tv, 16'h0009);
    slow_periods(3);
    slow_clk = 1'b1;
    tick(1);
    btn_clear = 1'b1;
    tick(4);
    btn_clear = 1'b0;
    tick(3);
    slow_clk = 1'b0;
    tick(8);
    check("clr_stick", tv, 16'h0000);
    check("clr_state", running, 1);
    slow_periods(4);
    check("clr_after", tv, 16'h0001);

    slow_periods(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("rst2_time", tv, 16'h0000);
    check("rst2_run", running, 0);
    press_pause();
    slow_periods(3);
    check("rst2_3q", tv, 16'h0000);
    slow_latency("rst2_lat");
    check("rst2_4q", tv, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
